// File: rtl/axil_mailbox_pkg.sv
// axil_mailbox_pkg: register offsets, response codes and FSM states for the AXI-Lite mailbox.
package axil_mailbox_pkg;
  localparam logic [11:0] TX_DATA_A = 12'h000;
  localparam logic [11:0] TX_VAC_A  = 12'h004;
  localparam logic [11:0] RX_DATA_A = 12'h008;
  localparam logic [11:0] RX_OCC_A  = 12'h00C;
  localparam logic [11:0] STATUS_A  = 12'h010;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;
endpackage

// File: rtl/axil_mailbox_fifo.sv
// axil_mailbox_fifo: 1R1W circular FIFO with full/empty/count; caller guarantees push/pop legality.
module axil_mailbox_fifo #(
  parameter int els_p = 16,
  parameter int width_p = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [width_p-1:0]       data_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  output logic [width_p-1:0]       data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(els_p):0]   count_o
);
  localparam int aw_lp = $clog2(els_p);
  logic [width_p-1:0] mem [els_p];
  logic [aw_lp-1:0] wp, rp;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      wp <= '0;
      rp <= '0;
      count_o <= '0;
    end else begin
      if (push_i) wp <= wp + aw_lp'(1);
      if (pop_i) rp <= rp + aw_lp'(1);
      count_o <= count_o + {{aw_lp{1'b0}}, push_i} - {{aw_lp{1'b0}}, pop_i};
    end
  always_ff @(posedge clk_i)
    if (push_i) mem[wp] <= data_i;
  assign data_o = mem[rp];
  assign full_o = count_o == (aw_lp+1)'(els_p);
  assign empty_o = count_o == '0;
endmodule

// File: rtl/axil_mailbox_slave.sv
// axil_mailbox_slave: AXI-Lite window bridging host MMIO to a TX stream (writes) and an RX stream (reads).
module axil_mailbox_slave
  import axil_mailbox_pkg::*;
#(
  parameter int fifo_els_p = 16,
  parameter int data_width_p = 32,
  parameter int addr_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [addr_width_p-1:0] s_axil_awaddr_i,
  input  logic                    s_axil_awvalid_i,
  output logic                    s_axil_awready_o,
  input  logic [data_width_p-1:0] s_axil_wdata_i,
  input  logic [3:0]              s_axil_wstrb_i,
  input  logic                    s_axil_wvalid_i,
  output logic                    s_axil_wready_o,
  output logic [1:0]              s_axil_bresp_o,
  output logic                    s_axil_bvalid_o,
  input  logic                    s_axil_bready_i,
  input  logic [addr_width_p-1:0] s_axil_araddr_i,
  input  logic                    s_axil_arvalid_i,
  output logic                    s_axil_arready_o,
  output logic [data_width_p-1:0] s_axil_rdata_o,
  output logic [1:0]              s_axil_rresp_o,
  output logic                    s_axil_rvalid_o,
  input  logic                    s_axil_rready_i,
  output logic [data_width_p-1:0] tx_data_o,
  output logic                    tx_v_o,
  input  logic                    tx_yumi_i,
  input  logic [data_width_p-1:0] rx_data_i,
  input  logic                    rx_v_i,
  output logic                    rx_ready_o
);
  localparam int cw_lp = $clog2(fifo_els_p) + 1;
  w_state_e w_state;
  r_state_e r_state;
  logic aw_held, w_held, alive, tx_of, rx_uf;
  logic [11:0] wa_q, wa, ra;
  logic [data_width_p-1:0] wd_q, wd, rd_val, rx_head;
  logic [3:0] ws_q, ws;
  logic aw_hs, w_hs, ar_hs, do_w, tx_wr, tx_push, tx_pop, tx_of_set, st_w, rx_rd, rx_push, rx_pop;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic [cw_lp-1:0] tx_cnt, rx_cnt;
  logic unused;
  assign unused = ^{s_axil_awaddr_i[addr_width_p-1:12], s_axil_araddr_i[addr_width_p-1:12]};
  assign aw_hs = s_axil_awvalid_i && s_axil_awready_o;
  assign w_hs = s_axil_wvalid_i && s_axil_wready_o;
  assign ar_hs = s_axil_arvalid_i && s_axil_arready_o;
  // Address/data come from the bus in the cycle of the completing handshake, else from the latch.
  assign wa = aw_held ? wa_q : s_axil_awaddr_i[11:0];
  assign wd = w_held ? wd_q : s_axil_wdata_i;
  assign ws = w_held ? ws_q : s_axil_wstrb_i;
  assign do_w = w_state == W_IDLE && (aw_held || aw_hs) && (w_held || w_hs);
  assign tx_pop = tx_yumi_i && !tx_empty;
  assign tx_wr = do_w && wa == TX_DATA_A && ws == 4'hF;
  assign tx_push = tx_wr && !(tx_full && !tx_pop);
  assign tx_of_set = tx_wr && tx_full && !tx_pop;
  assign st_w = do_w && wa == STATUS_A;
  assign ra = s_axil_araddr_i[11:0];
  assign rx_rd = ar_hs && ra == RX_DATA_A;
  assign rx_pop = rx_rd && !rx_empty;
  assign rx_ready_o = alive && !rx_full;
  assign rx_push = rx_v_i && rx_ready_o;
  assign tx_v_o = !tx_empty;
  assign rd_val = ra == TX_VAC_A  ? 32'(fifo_els_p) - 32'(tx_cnt) :
                  ra == RX_DATA_A ? (rx_empty ? '0 : rx_head) :
                  ra == RX_OCC_A  ? 32'(rx_cnt) :
                  ra == STATUS_A  ? {30'b0, rx_uf, tx_of} : '0;
  axil_mailbox_fifo #(.els_p(fifo_els_p), .width_p(data_width_p)) tx_fifo (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(wd), .push_i(tx_push), .pop_i(tx_pop),
    .data_o(tx_data_o), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt));
  axil_mailbox_fifo #(.els_p(fifo_els_p), .width_p(data_width_p)) rx_fifo (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(rx_data_i), .push_i(rx_push), .pop_i(rx_pop),
    .data_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt));
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      s_axil_awready_o <= 1'b0;
      s_axil_wready_o <= 1'b0;
      s_axil_bvalid_o <= 1'b0;
      s_axil_bresp_o <= RESP_OKAY;
      wa_q <= '0;
      wd_q <= '0;
      ws_q <= '0;
    end else if (w_state == W_IDLE) begin
      if (aw_hs) wa_q <= s_axil_awaddr_i[11:0];
      if (w_hs) begin
        wd_q <= s_axil_wdata_i;
        ws_q <= s_axil_wstrb_i;
      end
      aw_held <= (aw_held || aw_hs) && !do_w;
      w_held <= (w_held || w_hs) && !do_w;
      s_axil_awready_o <= !do_w && !(aw_held || aw_hs);
      s_axil_wready_o <= !do_w && !(w_held || w_hs);
      if (do_w) begin
        w_state <= W_RESP;
        s_axil_bvalid_o <= 1'b1;
        s_axil_bresp_o <= (wa == TX_DATA_A && !tx_push) ? RESP_SLVERR : RESP_OKAY;
      end
    end else if (s_axil_bready_i) begin
      w_state <= W_IDLE;
      s_axil_bvalid_o <= 1'b0;
      s_axil_awready_o <= 1'b1;
      s_axil_wready_o <= 1'b1;
    end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      r_state <= R_IDLE;
      s_axil_arready_o <= 1'b0;
      s_axil_rvalid_o <= 1'b0;
      s_axil_rdata_o <= '0;
      s_axil_rresp_o <= RESP_OKAY;
    end else if (r_state == R_IDLE) begin
      s_axil_arready_o <= !ar_hs;
      if (ar_hs) begin
        r_state <= R_RESP;
        s_axil_rvalid_o <= 1'b1;
        s_axil_rdata_o <= rd_val;
        s_axil_rresp_o <= (rx_rd && rx_empty) ? RESP_SLVERR : RESP_OKAY;
      end
    end else if (s_axil_rready_i) begin
      r_state <= R_IDLE;
      s_axil_rvalid_o <= 1'b0;
      s_axil_arready_o <= 1'b1;
    end
  // Sticky errors: a new error in the same cycle as its W1C keeps the bit set.
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      alive <= 1'b0;
      tx_of <= 1'b0;
      rx_uf <= 1'b0;
    end else begin
      alive <= 1'b1;
      tx_of <= tx_of_set || (tx_of && !(st_w && wd[0]));
      rx_uf <= (rx_rd && rx_empty) || (rx_uf && !(st_w && wd[1]));
    end
endmodule
